fifo_arb: RTL and testbench
===========================

FIFO_ARB -- requirements
Module: fifo_arb

Interface
REQ-001 Parameter NWR, default 4, meaning number of write requesters (2..8).
REQ-002 Parameter DW, default 8, meaning data width of the shared FIFO.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-low; sampled on rising clk, asserted when 0.
REQ-005 wr_req  input  NWR  per-requester write request, level, held until granted.
REQ-006 wr_data  input  NWR*DW  requester i write data in bits [i*DW +: DW].
REQ-007 wr_gnt  output  NWR  one-hot write grant; combinational; the granted word is consumed this cycle.
REQ-008 rd_req  input  1  read request from the single consumer, level.
REQ-009 rd_gnt  output  1  read grant; combinational; the read is issued to the FIFO this cycle.
REQ-010 rd_vld  output  1  registered pulse; FIFO rdata is valid this cycle (one cycle after rd_gnt).
REQ-011 fifo_en  output  1  FIFO enable; combinational.
REQ-012 fifo_wr_rd  output  1  1 = write, 0 = read; combinational.
REQ-013 fifo_wdata  output  DW  write data muxed from the granted requester; combinational.
REQ-014 fifo_full  input  1  FIFO full flag.
REQ-015 fifo_empty  input  1  FIFO empty flag.

Function
REQ-016 Each cycle, the block SHALL issue at most one FIFO operation: fifo_en = |wr_gnt | rd_gnt.
REQ-017 Write eligibility SHALL be |wr_req & !fifo_full; read eligibility SHALL be rd_req & !fifo_empty.
REQ-018 When only one operation class is eligible, the block SHALL grant that class.
REQ-019 When both classes are eligible, the block SHALL grant the class opposite to register last_op (0 = read, 1 = write), so writes and reads alternate.
REQ-020 last_op SHALL update to the granted class on every cycle with fifo_en = 1, and SHALL hold otherwise.
REQ-021 Among asserted wr_req bits, the block SHALL select by round-robin starting at pointer rr_ptr (width ceil(log2 NWR)), searching rr_ptr, rr_ptr+1, ... modulo NWR.
REQ-022 After a write grant to requester k, rr_ptr SHALL become (k+1) mod NWR; rr_ptr SHALL hold on cycles without a write grant.
REQ-023 wr_gnt SHALL be all-zero unless the write class is granted; rd_gnt and any wr_gnt bit SHALL never be asserted together.
REQ-024 fifo_wr_rd SHALL be 1 when a write is granted and 0 otherwise; fifo_wdata SHALL equal wr_data of the granted requester, and 0 when no write is granted.
REQ-025 rd_vld SHALL be rd_gnt delayed by exactly one clock.
REQ-026 When fifo_full = 1, no wr_gnt SHALL assert regardless of requests; when fifo_empty = 1, rd_gnt SHALL not assert.
REQ-027 Starvation bound: a continuously asserting write requester SHALL be granted within 2*NWR eligible-write cycles.
REQ-028 Outputs SHALL depend only on current inputs, rr_ptr and last_op; there are no other states.

Reset
REQ-029 While rst = 0, wr_gnt, rd_gnt, fifo_en and fifo_wr_rd SHALL be 0, and fifo_wdata SHALL be 0.
REQ-030 At a reset clock edge, rr_ptr SHALL be set to 0, last_op to 1 (so the first contended cycle grants a read), and rd_vld to 0.
REQ-031 Reset asserted mid-operation SHALL suppress any grant in that cycle, and rd_vld SHALL be 0 in the following cycle.

Verification
REQ-032 Reset, then wr_req = 4'b1111 with fifo_full = 0 and rd_req = 0 for 8 cycles -> wr_gnt sequence 0001, 0010, 0100, 1000, 0001, ...; fifo_wdata equals the granted lane.
REQ-033 wr_req = 4'b0100 and rd_req = 1, with the FIFO neither full nor empty, first cycle after reset -> rd_gnt = 1 (last_op reset = 1); next cycle wr_gnt = 0100; strict alternation after that; rd_vld pulses one cycle after each rd_gnt.
REQ-034 fifo_full = 1 with wr_req = 4'b1111 and rd_req = 1 -> only rd_gnt; fifo_wr_rd = 0; rr_ptr unchanged (next write goes to requester at held pointer).
REQ-035 fifo_empty = 1 with rd_req = 1 and wr_req = 0 -> fifo_en = 0, rd_gnt = 0, rd_vld = 0 next cycle.
REQ-036 Requesters 1 and 3 held high, rr_ptr = 2 -> grant 3, then 1, then 3 (pointer wrap past NWR-1).
REQ-037 rst = 0 driven while rd_gnt = 1 -> all grants 0 that cycle; rd_vld = 0 next cycle; after release the first write grant goes to requester 0.

Source files
------------

// File: rtl/fifo_arb.sv
// ---------------------------------------------------------------------------
// fifo_arb
//
// Arbitrates access to a single shared FIFO port. There are NWR write
// requesters and one read consumer. Each cycle at most one FIFO operation is
// issued. Writers are chosen by round-robin. When a write and a read are both
// eligible, the granted class alternates, starting with a read after reset.
//
// Parameters
//   NWR            number of write requesters (2..8)
//   DW             data width of the shared FIFO
//
// Ports
//   i_clk          sole clock, rising edge
//   i_rst          synchronous reset, active low
//   i_wr_req       per-requester write request (level, held until granted)
//   i_wr_data      requester i write data in bits [i*DW +: DW]
//   o_wr_gnt       one-hot write grant (combinational)
//   i_rd_req       consumer read request (level)
//   o_rd_gnt       read grant (combinational)
//   o_rd_vld       registered pulse one cycle after o_rd_gnt
//   o_fifo_en      FIFO enable (combinational)
//   o_fifo_wr_rd   1 = write, 0 = read (combinational)
//   o_fifo_wdata   write data of the granted requester, 0 when no write
//   i_fifo_full    FIFO full flag
//   i_fifo_empty   FIFO empty flag
// ---------------------------------------------------------------------------
module fifo_arb #(
  parameter int NWR = 4,
  parameter int DW  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NWR-1:0]    i_wr_req,
  input  logic [NWR*DW-1:0] i_wr_data,
  output logic [NWR-1:0]    o_wr_gnt,
  input  logic              i_rd_req,
  output logic              o_rd_gnt,
  output logic              o_rd_vld,
  output logic              o_fifo_en,
  output logic              o_fifo_wr_rd,
  output logic [DW-1:0]     o_fifo_wdata,
  input  logic              i_fifo_full,
  input  logic              i_fifo_empty
);

  localparam int PW = (NWR > 1) ? $clog2(NWR) : 1;

  // The class of the last issued operation. It decides who wins the next
  // contended cycle.
  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  op_e           r_lastOp;
  op_e           w_lastOpNext;
  logic [PW-1:0] r_rrPtr;
  logic [PW-1:0] w_rrPtrNext;
  logic          r_rdVld;

  logic          w_wrFound;
  logic [PW-1:0] w_wrIdx;
  logic          w_wrElig;
  logic          w_rdElig;
  logic          w_grantWr;
  logic          w_grantRd;
  logic [NWR-1:0] w_wrGnt;
  logic [DW-1:0]  w_wdata;

  // Round-robin search over the write requests, starting at r_rrPtr.
  // The loop walks the offsets from the farthest to the nearest, so the
  // requester closest to the pointer is the last one written and wins. The
  // modulo is done with a single conditional subtract. r_rrPtr is always
  // below NWR, so one subtract is enough.
  always_comb begin
    logic [PW:0] sum;
    w_wrFound = 1'b0;
    w_wrIdx   = '0;
    sum       = '0;
    for (int off = NWR - 1; off >= 0; off--) begin
      sum = {1'b0, r_rrPtr} + (PW+1)'(off);
      if (sum >= (PW+1)'(NWR)) begin
        sum = sum - (PW+1)'(NWR);
      end
      if (i_wr_req[sum[PW-1:0]]) begin
        w_wrFound = 1'b1;
        w_wrIdx   = sum[PW-1:0];
      end
    end
  end

  // Class arbitration and next-state logic for the last-op register and the
  // round-robin pointer. Reset is folded into both eligibilities. A cycle
  // with i_rst low therefore issues nothing, and the registers see no grant.
  // In a contended cycle the class opposite to r_lastOp wins. This makes
  // writes and reads strictly alternate when both keep asking.
  always_comb begin
    w_wrElig     = i_rst & w_wrFound & ~i_fifo_full;
    w_rdElig     = i_rst & i_rd_req & ~i_fifo_empty;
    w_grantWr    = 1'b0;
    w_grantRd    = 1'b0;
    w_lastOpNext = r_lastOp;
    w_rrPtrNext  = r_rrPtr;

    if (w_wrElig && w_rdElig) begin
      if (r_lastOp == OP_WRITE) begin
        w_grantRd = 1'b1;
      end else begin
        w_grantWr = 1'b1;
      end
    end else if (w_wrElig) begin
      w_grantWr = 1'b1;
    end else if (w_rdElig) begin
      w_grantRd = 1'b1;
    end

    if (w_grantWr) begin
      w_lastOpNext = OP_WRITE;
      if (w_wrIdx == PW'(NWR - 1)) begin
        w_rrPtrNext = '0;
      end else begin
        w_rrPtrNext = w_wrIdx + PW'(1);
      end
    end else if (w_grantRd) begin
      w_lastOpNext = OP_READ;
    end
  end

  // One-hot write grant and write data mux. The data bus is forced to zero
  // whenever no writer holds the grant.
  always_comb begin
    w_wrGnt = '0;
    w_wdata = '0;
    if (w_grantWr) begin
      w_wrGnt[w_wrIdx] = 1'b1;
    end
    for (int i = 0; i < NWR; i++) begin
      if (w_wrGnt[i]) begin
        w_wdata = i_wr_data[i*DW +: DW];
      end
    end
  end

  // State registers: round-robin pointer, last-op class and the read-valid
  // pulse. Reset sends the pointer to requester 0. Reset also sets the last op
  // to write, so the first contended cycle serves the reader.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_rrPtr  <= '0;
      r_lastOp <= OP_WRITE;
      r_rdVld  <= 1'b0;
    end else begin
      r_rrPtr  <= w_rrPtrNext;
      r_lastOp <= w_lastOpNext;
      r_rdVld  <= w_grantRd;
    end
  end

  assign o_wr_gnt     = w_wrGnt;
  assign o_rd_gnt     = w_grantRd;
  assign o_rd_vld     = r_rdVld;
  assign o_fifo_en    = w_grantWr | w_grantRd;
  assign o_fifo_wr_rd = w_grantWr;
  assign o_fifo_wdata = w_wdata;

  // Structural invariants of the grant outputs.
  aGntExclusive : assert property (@(posedge i_clk) disable iff (!i_rst)
    !(o_rd_gnt && (|o_wr_gnt)));
  aWrGntOneHot  : assert property (@(posedge i_clk) disable iff (!i_rst)
    $onehot0(o_wr_gnt));
  aNoWrWhenFull : assert property (@(posedge i_clk) disable iff (!i_rst)
    i_fifo_full |-> (o_wr_gnt == '0));
  aNoRdWhenEmpty : assert property (@(posedge i_clk) disable iff (!i_rst)
    i_fifo_empty |-> !o_rd_gnt);

endmodule

// File: tb/tb_fifo_arb.sv
// ---------------------------------------------------------------------------
// tb_fifo_arb
//
// Self-checking bench for fifo_arb (NWR = 4, DW = 8). A table of vectors is
// applied one per cycle, starting from reset. Each vector holds the inputs and
// the hand-derived grant expectations. The rd_vld expectation of each vector
// is queued and then compared one cycle later. A hand-written sequence then
// checks the starvation bound under full contention.
//
// Ports: none (top-level bench)
// ---------------------------------------------------------------------------
module tb_fifo_arb;

  localparam int NWR = 4;
  localparam int DW  = 8;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic [NWR-1:0]    i_wr_req;
  logic [NWR*DW-1:0] i_wr_data;
  logic [NWR-1:0]    o_wr_gnt;
  logic              i_rd_req;
  logic              o_rd_gnt;
  logic              o_rd_vld;
  logic              o_fifo_en;
  logic              o_fifo_wr_rd;
  logic [DW-1:0]     o_fifo_wdata;
  logic              i_fifo_full;
  logic              i_fifo_empty;

  fifo_arb #(.NWR(NWR), .DW(DW)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_wr_req     (i_wr_req),
    .i_wr_data    (i_wr_data),
    .o_wr_gnt     (o_wr_gnt),
    .i_rd_req     (i_rd_req),
    .o_rd_gnt     (o_rd_gnt),
    .o_rd_vld     (o_rd_vld),
    .o_fifo_en    (o_fifo_en),
    .o_fifo_wr_rd (o_fifo_wr_rd),
    .o_fifo_wdata (o_fifo_wdata),
    .i_fifo_full  (i_fifo_full),
    .i_fifo_empty (i_fifo_empty)
  );

  // 10-unit clock period.
  always #5 i_clk = ~i_clk;

  typedef struct {
    string          name;
    logic           rst;
    logic [NWR-1:0] wrReq;
    logic           rdReq;
    logic           full;
    logic           empty;
    logic [NWR-1:0] expWrGnt;
    logic           expRdGnt;
  } vec_t;

  vec_t vecs[$];
  logic expRdVldQ[$];
  int   nVectors     = 0;
  int   nChecks      = 0;
  int   nMiscompares = 0;

  // Each lane carries its own fixed pattern, so a wrong mux select is visible.
  function automatic logic [DW-1:0] laneData(input int i);
    return DW'(8'h11 * (i + 1));
  endfunction

  function automatic logic [DW-1:0] expWdata(input logic [NWR-1:0] g);
    logic [DW-1:0] d;
    d = '0;
    for (int i = 0; i < NWR; i++) begin
      if (g[i]) d = laneData(i);
    end
    return d;
  endfunction

  task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", n, act, exp);
    end
  endtask

  task automatic addVec(input string n, input logic rst, input logic [NWR-1:0] wr,
                        input logic rd, input logic full, input logic empty,
                        input logic [NWR-1:0] eWr, input logic eRd);
    vec_t v;
    v.name = n; v.rst = rst; v.wrReq = wr; v.rdReq = rd; v.full = full;
    v.empty = empty; v.expWrGnt = eWr; v.expRdGnt = eRd;
    vecs.push_back(v);
  endtask

  // Drive one vector at the falling edge, then let the combinational logic settle.
  task automatic applyStimulus(input vec_t v);
    @(negedge i_clk);
    i_rst        = v.rst;
    i_wr_req     = v.wrReq;
    i_rd_req     = v.rdReq;
    i_fifo_full  = v.full;
    i_fifo_empty = v.empty;
    nVectors++;
    #1;
  endtask

  // Compare the combinational outputs now. Pop the rd_vld expected from the
  // previous cycle, and queue this cycle's read grant for the next one.
  task automatic checkOutput(input vec_t v);
    logic eVld;
    cmp({v.name, ".wr_gnt"}, 32'(o_wr_gnt), 32'(v.expWrGnt));
    cmp({v.name, ".rd_gnt"}, 32'(o_rd_gnt), 32'(v.expRdGnt));
    cmp({v.name, ".fifo_en"}, 32'(o_fifo_en), 32'((|v.expWrGnt) | v.expRdGnt));
    cmp({v.name, ".fifo_wr_rd"}, 32'(o_fifo_wr_rd), 32'(|v.expWrGnt));
    cmp({v.name, ".fifo_wdata"}, 32'(o_fifo_wdata), 32'(expWdata(v.expWrGnt)));
    if (expRdVldQ.size() == 0) begin
      nChecks++;
      nMiscompares++;
      $display("[TB] FAIL %s.rd_vld: scoreboard empty, got %0b", v.name, o_rd_vld);
    end else begin
      eVld = expRdVldQ.pop_front();
      cmp({v.name, ".rd_vld"}, 32'(o_rd_vld), 32'(eVld));
    end
    expRdVldQ.push_back(v.expRdGnt);
  endtask

  // Global watchdog: the bench must never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bit found;
    int cycles;

    i_rst        = 1'b0;
    i_wr_req     = '0;
    i_rd_req     = 1'b0;
    i_fifo_full  = 1'b0;
    i_fifo_empty = 1'b0;
    for (int i = 0; i < NWR; i++) i_wr_data[i*DW +: DW] = laneData(i);

    // Arguments: name, rst, wrReq, rdReq, full, empty, expWrGnt, expRdGnt
    addVec("rst_hold",  1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
    addVec("rst_idle",  1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    addVec("rr1",       1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0);
    addVec("rr2",       1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0);
    addVec("rr3",       1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b0);
    addVec("rr4",       1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b0);
    addVec("rr5",       1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0);
    addVec("rr6",       1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0);
    addVec("rr7",       1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b0);
    addVec("rr8",       1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b0);
    addVec("set_ptr",   1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0);
    addVec("full_rd",   1'b1, 4'b1111, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1);
    addVec("full_idle", 1'b1, 4'b1111, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
    addVec("held_ptr",  1'b1, 4'b1111, 1'b1, 1'b0, 1'b1, 4'b0100, 1'b0);
    addVec("empty_rd",  1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0);
    addVec("empty_vld", 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    addVec("wrap_set",  1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0);
    addVec("wrap_a",    1'b1, 4'b1010, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b0);
    addVec("wrap_b",    1'b1, 4'b1010, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0);
    addVec("wrap_c",    1'b1, 4'b1010, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b0);
    addVec("rst_mid",   1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    addVec("alt1",      1'b1, 4'b0100, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1);
    addVec("alt2",      1'b1, 4'b0100, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b0);
    addVec("alt3",      1'b1, 4'b0100, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1);
    addVec("alt4",      1'b1, 4'b0100, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b0);
    addVec("alt5",      1'b1, 4'b0100, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1);
    addVec("rd_only",   1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1);
    addVec("rst_on_rd", 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
    addVec("post_rst",  1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0);
    addVec("post_ct1",  1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1);
    addVec("post_ct2",  1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0);

    // Reset is held from time 0, so rd_vld is 0 at the first check.
    expRdVldQ.push_back(1'b0);

    $display("[TB] applying %0d table vectors", vecs.size());
    foreach (vecs[k]) begin
      applyStimulus(vecs[k]);
      checkOutput(vecs[k]);
    end

    // Starvation: all writers and the reader contend from reset. Requester 3
    // must be reached within 2*NWR write-eligible cycles, and with strict
    // alternation that is exactly cycle 2*NWR.
    $display("[TB] starvation sequence");
    @(negedge i_clk);
    i_rst = 1'b0; i_wr_req = '0; i_rd_req = 1'b0;
    i_fifo_full = 1'b0; i_fifo_empty = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b1; i_wr_req = '1; i_rd_req = 1'b1;
    found  = 1'b0;
    cycles = 0;
    for (int c = 0; c < 4 * NWR && !found; c++) begin
      #1;
      nVectors++;
      cycles++;
      cmp("starve.exclusive", 32'(o_rd_gnt & (|o_wr_gnt)), 32'd0);
      if (o_wr_gnt[NWR-1]) found = 1'b1;
      @(negedge i_clk);
    end
    cmp("starve.granted", 32'(found), 32'd1);
    cmp("starve.cycles", 32'(cycles), 32'(2 * NWR));

    $display("[TB] %0d comparisons made", nChecks);
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
